// File: rtl/scan_seq_ctrl.sv
// rtl/scan_seq_ctrl.sv - scan sequencer: SR configuration load, injection bursts, FIFO drain per step
//
// Ports:
//   BUS_CLK, BUS_RST          clock (rising edge), asynchronous active-high reset
//   START, ABORT              single-cycle scan begin / stop requests
//   NUM_STEPS, NUM_INJ        steps per scan, injections per step (latched on START)
//   INJ_PERIOD, DRAIN_WAIT    injection spacing, required FIFO-empty run length (latched on START)
//   SPI_START / SPI_READY     configuration load trigger / SPI idle indication
//   INJ_START                 injection pulse generator trigger
//   FIFO_EMPTY / RX_EN        data-receiver FIFO empty / receiver enable
//   BUSY, DONE, ERROR         status: not idle, scan completed pulse, sticky timeout
//   STEP_CNT, INJ_CNT         completed steps, injections issued in the current step
//
// Optional feature: define SCAN_SEQ_TIMEOUT_EN to bound the time spent waiting on
// the SPI handshake; without it ERROR is tied low and no timeout counter exists.

module scan_seq_ctrl #(
    parameter int CNT_WIDTH  = 16,
    parameter int WAIT_WIDTH = 16
) (
    input  logic                  BUS_CLK,
    input  logic                  BUS_RST,
    input  logic                  START,
    input  logic                  ABORT,
    input  logic [CNT_WIDTH-1:0]  NUM_STEPS,
    input  logic [CNT_WIDTH-1:0]  NUM_INJ,
    input  logic [WAIT_WIDTH-1:0] INJ_PERIOD,
    input  logic [WAIT_WIDTH-1:0] DRAIN_WAIT,
    output logic                  SPI_START,
    input  logic                  SPI_READY,
    output logic                  INJ_START,
    input  logic                  FIFO_EMPTY,
    output logic                  RX_EN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERROR,
    output logic [CNT_WIDTH-1:0]  STEP_CNT,
    output logic [CNT_WIDTH-1:0]  INJ_CNT
);

    typedef enum logic [2:0] {
        IDLE, CONF, CONF_ACK, CONF_WAIT, INJ, INJ_WAIT, DRAIN, NEXT
    } state_t;

    state_t                state, state_d;
    logic                  done_q, done_d;
    logic [CNT_WIDTH-1:0]  step_cnt, inj_cnt, lat_steps, lat_inj;
    logic [WAIT_WIDTH-1:0] lat_period, lat_drain, wait_cnt, drain_cnt;
    logic                  latch, step_clr, step_inc, inj_clr, inj_inc;
    logic                  to_hit;

    logic [CNT_WIDTH-1:0]  step_nxt, inj_nxt;
    logic [WAIT_WIDTH-1:0] period_m1;
    logic                  drain_hit;

    assign step_nxt  = step_cnt + CNT_WIDTH'(1);
    assign inj_nxt   = inj_cnt + CNT_WIDTH'(1);
    // Number of INJ_WAIT cycles between pulses; periods of 0 and 1 both mean back-to-back.
    assign period_m1 = (lat_period == '0) ? '0 : lat_period - WAIT_WIDTH'(1);
    // drain_cnt holds the ones seen before this cycle, so this cycle completes the run.
    assign drain_hit = FIFO_EMPTY &&
                       ((lat_drain == '0) || (drain_cnt == lat_drain - WAIT_WIDTH'(1)));

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state      <= IDLE;
            done_q     <= 1'b0;
            step_cnt   <= '0;
            inj_cnt    <= '0;
            lat_steps  <= '0;
            lat_inj    <= '0;
            lat_period <= '0;
            lat_drain  <= '0;
            wait_cnt   <= '0;
            drain_cnt  <= '0;
        end else begin
            state  <= state_d;
            done_q <= done_d;
            if (latch) begin
                lat_steps  <= NUM_STEPS;
                lat_inj    <= NUM_INJ;
                lat_period <= INJ_PERIOD;
                lat_drain  <= DRAIN_WAIT;
            end
            if (step_clr)      step_cnt <= '0;
            else if (step_inc) step_cnt <= step_nxt;
            if (inj_clr)       inj_cnt  <= '0;
            else if (inj_inc)  inj_cnt  <= inj_nxt;
            // The INJ cycle itself is the first cycle of the period.
            if (state == INJ)  wait_cnt <= WAIT_WIDTH'(1);
            else               wait_cnt <= wait_cnt + WAIT_WIDTH'(1);
            if (state == DRAIN && FIFO_EMPTY) drain_cnt <= drain_cnt + WAIT_WIDTH'(1);
            else                              drain_cnt <= '0;
        end
    end

    always_comb begin
        state_d  = state;
        done_d   = 1'b0;
        latch    = 1'b0;
        step_clr = 1'b0;
        step_inc = 1'b0;
        inj_clr  = 1'b0;
        inj_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    latch = 1'b1;
                    if (NUM_STEPS == '0) begin
                        done_d = 1'b1;
                    end else begin
                        step_clr = 1'b1;
                        state_d  = CONF;
                    end
                end
            end
            CONF: state_d = CONF_ACK;
            CONF_ACK: begin
                if (to_hit)          state_d = IDLE;
                else if (!SPI_READY) state_d = CONF_WAIT;
            end
            CONF_WAIT: begin
                if (to_hit) begin
                    state_d = IDLE;
                end else if (SPI_READY) begin
                    inj_clr = 1'b1;
                    state_d = (lat_inj == '0) ? DRAIN : INJ;
                end
            end
            INJ: begin
                inj_inc = 1'b1;
                if (period_m1 != '0) state_d = INJ_WAIT;
                else                 state_d = (inj_nxt == lat_inj) ? DRAIN : INJ;
            end
            INJ_WAIT: begin
                if (wait_cnt == period_m1) state_d = (inj_cnt == lat_inj) ? DRAIN : INJ;
            end
            DRAIN: begin
                if (drain_hit) state_d = NEXT;
            end
            NEXT: begin
                step_inc = 1'b1;
                if (step_nxt == lat_steps) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = CONF;
                end
            end
            default: state_d = IDLE;
        endcase
        // ABORT overrides everything, including a START in IDLE, and freezes the counters.
        if (ABORT) begin
            state_d  = IDLE;
            done_d   = 1'b0;
            latch    = 1'b0;
            step_clr = 1'b0;
            step_inc = 1'b0;
            inj_clr  = 1'b0;
            inj_inc  = 1'b0;
        end
    end

`ifdef SCAN_SEQ_TIMEOUT_EN
    logic [WAIT_WIDTH-1:0] to_cnt;
    logic                  error_q;
    logic                  in_conf_wait;

    assign in_conf_wait = (state == CONF_ACK) || (state == CONF_WAIT);
    assign to_hit       = in_conf_wait && ((to_cnt + WAIT_WIDTH'(1)) == '1);

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            to_cnt  <= '0;
            error_q <= 1'b0;
        end else begin
            if (in_conf_wait) to_cnt <= to_cnt + WAIT_WIDTH'(1);
            else              to_cnt <= '0;
            if (to_hit && !ABORT) error_q <= 1'b1;
            else if (step_clr)    error_q <= 1'b0;
        end
    end

    assign ERROR = error_q;
`else
    assign to_hit = 1'b0;
    assign ERROR  = 1'b0;
`endif

    // Strobes are pure state decodes so reset clears them without waiting for a clock.
    assign SPI_START = (state == CONF);
    assign INJ_START = (state == INJ);
    assign RX_EN     = (state == INJ) || (state == INJ_WAIT) || (state == DRAIN);
    assign BUSY      = (state != IDLE);
    assign DONE      = done_q;
    assign STEP_CNT  = step_cnt;
    assign INJ_CNT   = inj_cnt;

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// tb/tb_scan_seq_ctrl.sv - directed self-checking bench for scan_seq_ctrl

module tb_scan_seq_ctrl;

    logic        bus_clk;
    logic        bus_rst;
    logic        start, abort;
    logic [15:0] num_steps, num_inj, inj_period, drain_wait;
    logic        spi_start, spi_ready, inj_start, fifo_empty;
    logic        rx_en, busy, done, error;
    logic [15:0] step_cnt, inj_cnt;

    logic        spi_auto, spi_force, spi_model_rdy;
    int          spi_busy;
    int          vectors, miscompares;
    int          cyc, spi_n, inj_n, done_n, overlap_n;
    int          inj_t [0:63];
    int          s0, i0, d0;
    int          fe_seq [0:6];

    scan_seq_ctrl #(.CNT_WIDTH(16), .WAIT_WIDTH(16)) dut (
        .BUS_CLK   (bus_clk),
        .BUS_RST   (bus_rst),
        .START     (start),
        .ABORT     (abort),
        .NUM_STEPS (num_steps),
        .NUM_INJ   (num_inj),
        .INJ_PERIOD(inj_period),
        .DRAIN_WAIT(drain_wait),
        .SPI_START (spi_start),
        .SPI_READY (spi_ready),
        .INJ_START (inj_start),
        .FIFO_EMPTY(fifo_empty),
        .RX_EN     (rx_en),
        .BUSY      (busy),
        .DONE      (done),
        .ERROR     (error),
        .STEP_CNT  (step_cnt),
        .INJ_CNT   (inj_cnt)
    );

    initial bus_clk = 1'b0;
    always #5 bus_clk = ~bus_clk;

    // SPI responder: goes busy for three cycles after each load request.
    initial begin
        spi_busy      = 0;
        spi_model_rdy = 1'b1;
    end
    always @(negedge bus_clk) begin
        if (spi_start) spi_busy = 3;
        if (spi_busy > 0) begin
            spi_model_rdy = 1'b0;
            spi_busy--;
        end else begin
            spi_model_rdy = 1'b1;
        end
    end
    assign spi_ready = spi_auto ? spi_model_rdy : spi_force;

    initial begin
        cyc = 0; spi_n = 0; inj_n = 0; done_n = 0; overlap_n = 0;
    end
    always @(negedge bus_clk) begin
        cyc++;
        if (spi_start) spi_n++;
        if (inj_start) begin
            if (inj_n < 64) inj_t[inj_n] = cyc;
            inj_n++;
        end
        if (done) done_n++;
        if (spi_start && inj_start) overlap_n++;
    end

    task automatic tick();
        @(posedge bus_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        bus_rst = 1'b1; start = 1'b0; abort = 1'b0;
        num_steps = '0; num_inj = '0; inj_period = '0; drain_wait = '0;
        fifo_empty = 1'b1; spi_auto = 1'b1; spi_force = 1'b1;
        fe_seq = '{1, 1, 0, 1, 1, 1, 1};

        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_rx_en", rx_en, 0);
        check("rst_spi_start", spi_start, 0);
        check("rst_step_cnt", step_cnt, 0);
        check("rst_inj_cnt", inj_cnt, 0);
        bus_rst = 1'b0;
        tick();

        // Basic scan; NUM_STEPS changed after START must be ignored.
        num_steps = 2; num_inj = 3; inj_period = 10; drain_wait = 4;
        s0 = spi_n; i0 = inj_n; d0 = done_n;
        start = 1'b1; tick(); start = 1'b0; num_steps = 5;
        check("basic_conf_spi_start", spi_start, 1);
        check("basic_conf_busy", busy, 1);
        for (int k = 0; k < 300 && !done; k++) tick();
        check("basic_done", done, 1);
        check("basic_step_cnt", step_cnt, 2);
        check("basic_inj_cnt", inj_cnt, 3);
        check("basic_idle", busy, 0);
        tick();
        check("basic_done_single", done, 0);
        check("basic_spi_pulses", spi_n - s0, 2);
        check("basic_inj_pulses", inj_n - i0, 6);
        check("basic_done_pulses", done_n - d0, 1);
        check("basic_gap_s1a", inj_t[i0 + 1] - inj_t[i0], 10);
        check("basic_gap_s1b", inj_t[i0 + 2] - inj_t[i0 + 1], 10);
        check("basic_gap_s2a", inj_t[i0 + 4] - inj_t[i0 + 3], 10);
        check("basic_gap_s2b", inj_t[i0 + 5] - inj_t[i0 + 4], 10);
        check("basic_no_overlap", overlap_n, 0);

        // Zero steps: DONE one cycle after START, no configuration load.
        num_steps = 0; s0 = spi_n;
        start = 1'b1; tick(); start = 1'b0;
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        tick();
        check("zero_done_end", done, 0);
        check("zero_no_spi", spi_n - s0, 0);

        // Zero injections plus drain run pattern 1,1,0,1,1,1,1 with DRAIN_WAIT=4.
        num_steps = 1; num_inj = 0; drain_wait = 4; fifo_empty = 1'b0;
        i0 = inj_n;
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 50 && !rx_en; k++) tick();
        check("drain_entered", rx_en, 1);
        for (int i = 0; i < 7; i++) begin
            fifo_empty = fe_seq[i][0];
            tick();
            if (i < 6) begin
                check("drain_hold", rx_en, 1);
            end else begin
                check("drain_exit_rx_en", rx_en, 0);
                check("drain_exit_busy", busy, 1);
            end
        end
        tick();
        check("drain_done", done, 1);
        check("drain_step_cnt", step_cnt, 1);
        check("drain_no_inj", inj_n - i0, 0);
        fifo_empty = 1'b1;

        // ABORT together with START during INJ_WAIT.
        num_steps = 1; num_inj = 3; inj_period = 10; drain_wait = 4;
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 50 && !inj_start; k++) tick();
        check("abort_first_inj", inj_start, 1);
        tick(); tick(); tick();
        check("abort_in_inj_wait", rx_en, 1);
        d0 = done_n;
        abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_rx_en", rx_en, 0);
        check("abort_inj_cnt", inj_cnt, 1);
        check("abort_step_cnt", step_cnt, 0);
        repeat (5) tick();
        check("abort_stays_idle", busy, 0);
        check("abort_no_done", done_n - d0, 0);

        // SPI_READY stuck high: default build waits in CONF_ACK indefinitely.
        spi_auto = 1'b0; spi_force = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        check("stuck_spi_start", spi_start, 1);
        repeat (20) tick();
        check("stuck_busy", busy, 1);
        check("stuck_rx_en", rx_en, 0);
        check("stuck_error", error, 0);
        check("stuck_no_inj", inj_start, 0);
        abort = 1'b1; tick(); abort = 1'b0;
        check("stuck_abort_idle", busy, 0);
        spi_auto = 1'b1;
        tick();

        // Asynchronous reset in the second step's INJ_WAIT.
        num_steps = 2; num_inj = 3; inj_period = 10;
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 200 && !(step_cnt == 1 && inj_start); k++) tick();
        check("rst_mid_reached", step_cnt, 1);
        tick(); tick(); tick();
        d0 = done_n;
        #2 bus_rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_rx_en", rx_en, 0);
        check("arst_step_cnt", step_cnt, 0);
        check("arst_inj_cnt", inj_cnt, 0);
        check("arst_inj_start", inj_start, 0);
        check("arst_spi_start", spi_start, 0);
        check("arst_done", done, 0);
        tick();
        bus_rst = 1'b0;
        tick();
        check("arst_no_done", done_n - d0, 0);

        num_steps = 1; num_inj = 1;
        s0 = spi_n; i0 = inj_n;
        start = 1'b1; tick(); start = 1'b0;
        check("clean_step_cnt", step_cnt, 0);
        check("clean_spi_start", spi_start, 1);
        for (int k = 0; k < 100 && !done; k++) tick();
        check("clean_done", done, 1);
        check("clean_step_final", step_cnt, 1);
        check("clean_inj_cnt", inj_cnt, 1);
        check("clean_inj_pulses", inj_n - i0, 1);
        check("clean_spi_pulses", spi_n - s0, 1);
        check("final_no_overlap", overlap_n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
